// File: rtl/z80_bus_pkg.sv
// Purpose : shared types and constants for the z80 bus responder.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
package z80_bus_pkg;

  // Width of the wait-state counter, which bounds the wait count to 0..15.
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_INTA
  } cyc_e;

  function automatic logic cyc_is_write(cyc_e kind);
    return (kind == CYC_MEM_WR) || (kind == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/z80_bus_if.sv
// Purpose : tv80s-side CPU bus bundle (address, data, strobes, wait).
// Latency : n/a (wiring only).
// Backpressure: the responder stalls the CPU by pulling wait_n low.
// Ports   : master = CPU side, drives address/data/strobes.
//           slave  = responder side, drives d_out and wait_n.
interface z80_bus_if;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic        wait_n;

  modport master (
    output a, d_in, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    input  d_out, wait_n
  );

  modport slave (
    input  a, d_in, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    output d_out, wait_n
  );
endinterface

// File: rtl/z80_bus_ram.sv
// Purpose : 64K x 8 byte store with a CPU port and a debug port, both synchronous.
// Latency : reads registered, 1 cycle; writes commit on the clock edge.
// Backpressure: none; a same-address write collision lets the CPU port win.
// Ports   : clk/reset_n; cpu_we/cpu_re/cpu_addr/cpu_wdata -> cpu_rdata (held when cpu_re=0);
//           dbg_we/dbg_addr/dbg_wdata -> dbg_rdata (updated every cycle).
module z80_bus_ram (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic [7:0]  dbg_rdata
);

  // Contents are deliberately outside reset: reset never clears the store.
  logic [7:0] mem [0:65535];

  logic [7:0] cpu_rdata_d, cpu_rdata_q;
  logic [7:0] dbg_rdata_d, dbg_rdata_q;
  logic       dbg_wr_ok;

  always_comb begin
    // Debug write is suppressed when the CPU writes the same byte this cycle.
    dbg_wr_ok   = dbg_we && !(cpu_we && (cpu_addr == dbg_addr));
    cpu_rdata_d = cpu_rdata_q;
    if (cpu_re) begin
      cpu_rdata_d = mem[cpu_addr];
    end
    // Read of the pre-edge contents: a same-cycle write shows up one cycle later.
    dbg_rdata_d = mem[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (cpu_we) begin
      mem[cpu_addr] <= cpu_wdata;
    end
    if (dbg_wr_ok) begin
      mem[dbg_addr] <= dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rdata_q <= 8'h00;
      dbg_rdata_q <= 8'h00;
    end else begin
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Purpose : answers tv80s memory, I/O and interrupt-acknowledge cycles from a 64 KiB store.
// Latency : read data / write commit 1+N cycles after the IDLE sample edge (N wait states).
// Backpressure: wait_n held low for exactly N cycles; one access per CPU cycle until strobes rise.
// Ports   : clk, reset_n (sync, active low); bus = CPU bus (slave modport);
//           dbg_we/dbg_addr/dbg_wdata/dbg_rdata = side-band store access, 1-cycle read latency.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter logic [WAIT_W-1:0] WAIT_MEM    = 4'd0,
  parameter logic [WAIT_W-1:0] WAIT_IO     = 4'd1,
  parameter logic [7:0]        IO_PAGE     = 8'h10,
  parameter logic [7:0]        INTA_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  z80_bus_if.slave    bus,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic [7:0]  dbg_rdata
);

  localparam logic [WAIT_W-1:0] CNT_ZERO = '0;
  localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);

  state_e            state_d, state_q;
  cyc_e              kind_d, kind_q;
  logic [15:0]       addr_d, addr_q;
  logic [WAIT_W-1:0] cnt_d, cnt_q;
  // Selects the interrupt vector onto d_out instead of the store read register.
  logic              inta_sel_d, inta_sel_q;

  logic              cpu_we;
  logic              cpu_re;
  logic [7:0]        cpu_rdata;
  logic              strobes_idle;
  logic              rd_or_wr;

  assign strobes_idle = bus.mreq_n && bus.iorq_n && bus.rd_n && bus.wr_n;
  assign rd_or_wr     = !bus.rd_n || !bus.wr_n;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inta_sel_d = inta_sel_q;
    cpu_we     = 1'b0;
    cpu_re     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.rfsh_n) begin
          // Refresh cycles carry a row address only; nothing to answer.
          state_d = ST_IDLE;
        end else if (!bus.m1_n && !bus.iorq_n) begin
          kind_d     = CYC_INTA;
          inta_sel_d = 1'b1;
          state_d    = ST_DONE;
        end else if (!bus.mreq_n && rd_or_wr) begin
          kind_d  = !bus.rd_n ? CYC_MEM_RD : CYC_MEM_WR;
          addr_d  = bus.a;
          cnt_d   = WAIT_MEM;
          state_d = (WAIT_MEM != CNT_ZERO) ? ST_WAIT : ST_XFER;
        end else if (!bus.iorq_n && rd_or_wr) begin
          kind_d  = !bus.rd_n ? CYC_IO_RD : CYC_IO_WR;
          addr_d  = {IO_PAGE, bus.a[7:0]};
          cnt_d   = WAIT_IO;
          state_d = (WAIT_IO != CNT_ZERO) ? ST_WAIT : ST_XFER;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        // Write data is taken live from the bus in this cycle, so a CPU that
        // changes d_in later in the strobe cannot affect the stored byte.
        if (cyc_is_write(kind_q)) begin
          cpu_we = 1'b1;
        end else begin
          cpu_re     = 1'b1;
          inta_sel_d = 1'b0;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (strobes_idle) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      kind_q     <= CYC_MEM_RD;
      addr_q     <= 16'h0000;
      cnt_q      <= CNT_ZERO;
      inta_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inta_sel_q <= inta_sel_d;
    end
  end

  // cpu_we depends only on the registered state, so a write already in XFER
  // commits even if reset is asserted in that same cycle.
  z80_bus_ram u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (addr_q),
    .cpu_wdata (bus.d_in),
    .cpu_rdata (cpu_rdata),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
  );

  assign bus.wait_n = (state_q != ST_WAIT);
  assign bus.d_out  = inta_sel_q ? INTA_VECTOR : cpu_rdata;

endmodule

// File: tb/tb_z80_bus_responder.sv
module tb_z80_bus_responder;

  localparam logic [3:0] WM  = 4'd2;
  localparam logic [3:0] WI  = 4'd1;
  localparam logic [7:0] IOP = 8'h10;
  localparam logic [7:0] IV  = 8'hFF;

  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_IORD = 2;
  localparam int K_IOWR = 3;
  localparam int K_INTA = 4;
  localparam int K_RFSH = 5;
  localparam int K_RST  = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic [7:0]  dbg_rdata;

  always #5 clk = ~clk;

  z80_bus_if bus ();

  z80_bus_responder #(
    .WAIT_MEM    (WM),
    .WAIT_IO     (WI),
    .IO_PAGE     (IOP),
    .INTA_VECTOR (IV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
  );

  // Expected shape of one CPU cycle, indexed by samples j=0,1,... taken just
  // after each edge starting with the edge that first sees the strobes:
  // wait_n low for j < n_wait; d_out = prev for j < lat, nxt from j = lat on.
  typedef struct {
    int         kind;
    int         n_wait;
    int         lat;
    logic [7:0] prev;
    logic [7:0] nxt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] dbg_q[$];
  logic [7:0] mem_m [0:65535];
  logic [7:0] cur_dout;
  bit         dbg_chk;
  bit         mon_en;

  int total = 0;
  int bad   = 0;

  logic [15:0] pool [12] = '{16'h2C39, 16'h0000, 16'hFFFF, 16'h1039, 16'h1000, 16'h10FF,
                             16'h105A, 16'h8001, 16'h7FFE, 16'h4000, 16'h1234, 16'hBEEF};
  logic [7:0]  ports [4] = '{8'h39, 8'h00, 8'hFF, 8'h5A};

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic idle_strobes();
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.m1_n   = 1'b1;
    bus.rfsh_n = 1'b1;
  endtask

  task automatic dbg_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    dbg_we    = 1'b1;
    dbg_addr  = addr;
    dbg_wdata = data;
    mem_m[addr] = data;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic dbg_read(input logic [15:0] addr);
    @(negedge clk);
    dbg_addr = addr;
    dbg_chk  = 1'b1;
    dbg_q.push_back(mem_m[addr]);
    @(negedge clk);
    dbg_chk = 1'b0;
  endtask

  // One CPU cycle: strobes asserted for the wait states, the transfer cycle
  // and 'extra' further cycles; d_in is corrupted right after the transfer.
  task automatic cpu_cycle(input int k, input logic [15:0] addr, input logic [7:0] data,
                           input int extra, input bit coll);
    int          n;
    logic [15:0] eff;
    exp_t        e;
    bit          is_io;
    bit          is_wr;
    is_io = (k == K_IORD) || (k == K_IOWR);
    is_wr = (k == K_MWR) || (k == K_IOWR);
    eff   = is_io ? {IOP, addr[7:0]} : addr;
    n     = (k == K_MRD || k == K_MWR) ? int'(WM) : (is_io ? int'(WI) : 0);
    e.kind   = k;
    e.n_wait = n;
    e.lat    = 0;
    e.prev   = cur_dout;
    e.nxt    = cur_dout;
    if (k == K_MRD || k == K_IORD) begin
      e.lat = n + 1;
      e.nxt = mem_m[eff];
    end else if (k == K_INTA) begin
      e.nxt = IV;
    end
    exp_q.push_back(e);
    cur_dout = e.nxt;

    @(negedge clk);
    bus.a    = addr;
    bus.d_in = data;
    case (k)
      K_MRD:  begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
      K_MWR:  begin bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
      K_IORD: begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
      K_IOWR: begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
      K_INTA: begin bus.m1_n = 1'b0; bus.iorq_n = 1'b0; end
      default: begin bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; end
    endcase
    repeat (n + 1) @(negedge clk);
    // Now inside the transfer cycle.
    if (coll && is_wr) begin
      dbg_we    = 1'b1;
      dbg_addr  = eff;
      dbg_wdata = ~data;
      dbg_chk   = 1'b1;
      dbg_q.push_back(mem_m[eff]);
    end
    @(negedge clk);
    bus.d_in = ~data;
    dbg_we   = 1'b0;
    dbg_chk  = 1'b0;
    repeat (extra) @(negedge clk);
    idle_strobes();
    if (is_wr) mem_m[eff] = data;
    @(negedge clk);
  endtask

  // Memory write aborted by reset in its first wait-state cycle.
  task automatic reset_in_wait(input logic [15:0] addr, input logic [7:0] data);
    exp_t e;
    e.kind   = K_RST;
    e.n_wait = 1;
    e.lat    = 1;
    e.prev   = cur_dout;
    e.nxt    = 8'h00;
    exp_q.push_back(e);
    cur_dout = 8'h00;
    @(negedge clk);
    bus.a      = addr;
    bus.d_in   = data;
    bus.mreq_n = 1'b0;
    bus.wr_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_strobes();
    @(negedge clk);
  endtask

  // Bus monitor: recognises CPU cycles from the strobes and compares the
  // responder's wait_n / d_out against the queued expectation.
  initial begin
    bit   active;
    bit   bus_act;
    int   j;
    exp_t e;
    active = 1'b0;
    j      = 0;
    e      = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        bus_act = !(bus.mreq_n && bus.iorq_n && bus.rd_n && bus.wr_n);
        if (!active && bus_act) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cycle: got a bus cycle, expected none");
          end else begin
            e = exp_q.pop_front();
            active = 1'b1;
            j = 0;
          end
        end
        if (active && bus_act) begin
          check($sformatf("wait_n k%0d j%0d", e.kind, j), {15'd0, bus.wait_n},
                {15'd0, (j < e.n_wait) ? 1'b0 : 1'b1});
          check($sformatf("d_out k%0d j%0d", e.kind, j), {8'd0, bus.d_out},
                {8'd0, (j < e.lat) ? e.prev : e.nxt});
          j++;
        end else if (active) begin
          total++;
          if (j <= e.lat || j < e.n_wait) begin
            bad++;
            $display("FAIL cycle_len k%0d: got %0d samples, expected more than %0d", e.kind, j, e.lat);
          end
          active = 1'b0;
        end else begin
          check("wait_n idle", {15'd0, bus.wait_n}, 16'd1);
        end
      end
    end
  end

  // Debug-port monitor: dbg_rdata one cycle after a flagged address.
  initial begin
    bit         c;
    logic [7:0] ev;
    forever begin
      @(posedge clk);
      c = dbg_chk;
      #1;
      if (c) begin
        if (dbg_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dbg_unexpected: got read %h, expected none", dbg_rdata);
        end else begin
          ev = dbg_q.pop_front();
          check($sformatf("dbg_rdata @%h", dbg_addr), {8'd0, dbg_rdata}, {8'd0, ev});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int k;
    reset_n   = 1'b0;
    idle_strobes();
    bus.a     = 16'h0000;
    bus.d_in  = 8'h00;
    dbg_we    = 1'b0;
    dbg_addr  = 16'h0000;
    dbg_wdata = 8'h00;
    dbg_chk   = 1'b0;
    mon_en    = 1'b0;
    cur_dout  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset wait_n", {15'd0, bus.wait_n}, 16'd1);
    check("reset d_out", {8'd0, bus.d_out}, 16'h0000);
    check("reset dbg_rdata", {8'd0, dbg_rdata}, 16'h0000);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 12; i++) dbg_write(pool[i], 8'($urandom_range(0, 255)));

    // Memory read of a preloaded byte.
    dbg_write(16'h2C39, 8'hC8);
    cpu_cycle(K_MRD, 16'h2C39, 8'h00, 0, 1'b0);
    // I/O write lands in the I/O page.
    cpu_cycle(K_IOWR, 16'hAB39, 8'h5A, 0, 1'b0);
    dbg_read(16'h1039);
    cpu_cycle(K_IORD, 16'h7739, 8'h00, 1, 1'b0);
    // Long write strobe: single commit of the transfer-cycle byte.
    cpu_cycle(K_MWR, 16'h4000, 8'h11, 4, 1'b0);
    dbg_read(16'h4000);
    // INTA then refresh; store must be unchanged.
    cpu_cycle(K_INTA, 16'h0000, 8'h00, 1, 1'b0);
    dbg_read(16'h2C39);
    cpu_cycle(K_RFSH, 16'h2C39, 8'h00, 1, 1'b0);
    dbg_read(16'h2C39);
    // Address extremes.
    cpu_cycle(K_MWR, 16'hFFFF, 8'hA5, 0, 1'b0);
    cpu_cycle(K_MRD, 16'hFFFF, 8'h00, 0, 1'b0);
    cpu_cycle(K_MRD, 16'h0000, 8'h00, 0, 1'b0);
    // CPU and debug write the same byte in the same cycle.
    cpu_cycle(K_MWR, 16'h8001, 8'h3C, 0, 1'b1);
    dbg_read(16'h8001);
    // Reset while in a wait state: write dropped, outputs back to reset values.
    reset_in_wait(16'h7FFE, 8'h99);
    dbg_read(16'h7FFE);
    cpu_cycle(K_MRD, 16'h7FFE, 8'h00, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        k = r;
        if (k == K_IORD || k == K_IOWR)
          cpu_cycle(k, {8'($urandom_range(0, 255)), ports[$urandom_range(0, 3)]},
                    8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0);
        else
          cpu_cycle(k, pool[$urandom_range(0, 11)], 8'($urandom_range(0, 255)),
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end else if (r <= 7) begin
        dbg_read(pool[$urandom_range(0, 11)]);
      end else if (r == 8) begin
        dbg_write(pool[$urandom_range(0, 11)], 8'($urandom_range(0, 255)));
      end else begin
        reset_in_wait(pool[$urandom_range(0, 11)], 8'($urandom_range(0, 255)));
      end
    end

    repeat (5) @(negedge clk);
    check("bus queue drained", 16'(exp_q.size()), 16'd0);
    check("dbg queue drained", 16'(dbg_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Synchronous bus responder that sits on the tv80s CPU side bus and answers its memory, I/O and interrupt-acknowledge cycles. It holds a 64 KiB byte store, maps I/O ports into a fixed page of that store, and inserts programmable wait states through `wait_n`. A debug port lets benches preload and inspect memory without running CPU cycles.

## Interface

Parameters:

- `WAIT_MEM`, default 0: wait states inserted on memory read/write cycles (0–15).
- `WAIT_IO`, default 1: wait states inserted on I/O read/write cycles (0–15).
- `IO_PAGE`, default 8'h10: I/O port `p` maps to store address `{IO_PAGE, p[7:0]}`.
- `INTA_VECTOR`, default 8'hFF: byte driven on interrupt acknowledge.

Ports:

- `clk` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `a` in 16: CPU address.
- `d_in` in 8: CPU write data (tv80s `dout`).
- `d_out` out 8: read data to the CPU (tv80s `di`).
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfsh_n` in 1 each: CPU strobes, active-low.
- `wait_n` out 1: wait request to the CPU, active-low.
- `dbg_we` in 1: debug write enable.
- `dbg_addr` in 16: debug address.
- `dbg_wdata` in 8: debug write data.
- `dbg_rdata` out 8: store contents at `dbg_addr`, registered with 1-cycle latency.

## Operation

States: IDLE, WAIT, XFER, DONE.

IDLE samples the strobes every cycle. Decoding priority:

1. `rfsh_n`=0: refresh. Ignored; stay in IDLE.
2. `m1_n`=0 and `iorq_n`=0: INTA. `d_out`<=`INTA_VECTOR`; go to DONE. No store access.
3. `mreq_n`=0 with `rd_n`=0 or `wr_n`=0: memory read or write.
4. `iorq_n`=0 with `rd_n`=0 or `wr_n`=0: I/O read or write.

On a valid request:

- Capture the cycle kind and the effective address (`a`, or the I/O-mapped address).
- Load the wait counter with `WAIT_MEM` or `WAIT_IO`.
- Go to WAIT if the counter is non-zero, otherwise to XFER.

WAIT:

- `wait_n`=0.
- Counter decrements each cycle. Move to XFER in the cycle the counter reaches 0.

XFER, one cycle:

- Read: `d_out`<=store[addr].
- Write: store[addr]<=`d_in` as sampled in this cycle.
- Go to DONE.

DONE:

- Hold `d_out`.
- Return to IDLE once `mreq_n`, `iorq_n`, `rd_n` and `wr_n` are all 1.
- At most one store write per CPU cycle, however long `wr_n` stays low.

Outputs:

- `wait_n` = 0 only in WAIT.
- `d_out` changes only in XFER or on INTA.
- Reset values: `wait_n`=1, `d_out`=8'h00, `dbg_rdata`=8'h00, state IDLE.

## Timing

- Read latency from the IDLE sample edge to `d_out` valid: 1+N cycles (N = wait states).
- Write commit happens 1+N cycles after the IDLE sample edge.
- `wait_n` falls the cycle after the IDLE sample edge and stays low for exactly N cycles.
- Debug and CPU writes to the same address in the same cycle: the CPU write wins.
- Debug read of an address being written in the same cycle returns the old value.
- Address wrap-around: none. The full 16-bit space is backed.
- Reset mid-operation (any state): next cycle is IDLE with reset output values.
  - Any in-flight write is dropped unless already in XFER.
  - Store contents are never cleared by reset.
- Strobes still asserted in the first cycle after reset are serviced as a new request.

## Structure

- Package `z80_bus_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_WAIT`, `ST_XFER`, `ST_DONE`);
  - the cycle-kind enum (`CYC_MEM_RD`, `CYC_MEM_WR`, `CYC_IO_RD`, `CYC_IO_WR`, `CYC_INTA`);
  - the 4-bit wait-counter width constant.
- Sub-module `z80_bus_ram`: 64K×8 store with two synchronous ports.
  - CPU port: read/write.
  - Debug port: read/write.
  - Write-collision priority given to the CPU port.

## Test plan

1. **Memory read, no waits.** Debug-write store[16'h2C39]=8'hC8; `WAIT_MEM`=0; `mreq_n`=`rd_n`=0, `a`=16'h2C39 → `d_out`=8'hC8 one cycle after the sample edge; `wait_n` stays 1.
2. **I/O write with one wait.** `WAIT_IO`=1; `iorq_n`=`wr_n`=0, `a`=16'hAB39, `d_in`=8'h5A → `wait_n`=0 for exactly 1 cycle; debug read of 16'h1039 returns 8'h5A.
3. **Long write strobe.** `mreq_n`=`wr_n`=0 held 6 cycles, `WAIT_MEM`=2; `d_in` is 8'h11 in the XFER cycle, then 8'h22 → store[a]=8'h11 (single write); state returns to IDLE after the strobes rise.
4. **INTA.** `m1_n`=`iorq_n`=0 → `d_out`=8'hFF next cycle; store unchanged; no `wait_n` assertion.
5. **Refresh.** `mreq_n`=`rfsh_n`=0, `rd_n`=1 → state stays IDLE; `d_out` and store unchanged.
6. **Reset in WAIT.** `WAIT_MEM`=3, start a memory write, drive `reset_n`=0 while in WAIT → next cycle `wait_n`=1, `d_out`=8'h00; target byte retains its preloaded value.
